// File: rtl/dmux1t8_8_reg.sv
// dmux1t8_8_reg: 1-to-8 registered demultiplexer.
// Each output channel has a valid flag and a consume strobe.
// The target channel comes from sel, or from an internal round-robin pointer when auto=1.
module dmux1t8_8_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] x,
  input  logic [2:0]   sel,
  input  logic         auto,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   clr,
  output logic [W-1:0] o0,
  output logic [W-1:0] o1,
  output logic [W-1:0] o2,
  output logic [W-1:0] o3,
  output logic [W-1:0] o4,
  output logic [W-1:0] o5,
  output logic [W-1:0] o6,
  output logic [W-1:0] o7,
  output logic [7:0]   vld,
  output logic [2:0]   ptr,
  output logic         full
);

  logic [7:0][W-1:0] data_q, data_d;
  logic [7:0]        vld_q, vld_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        target;
  logic              accept;

  // Pick the target channel and decide whether it can take a word this cycle.
  always_comb begin
    target   = auto ? ptr_q : sel;
    in_ready = ~vld_q[target] | clr[target];
    accept   = in_valid & in_ready;
  end

  // Next state: clears apply first, and an accept then overrides the target channel's valid flag.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q & ~clr;
    ptr_d  = ptr_q;
    if (accept) begin
      data_d[target] = x;
      vld_d[target]  = 1'b1;
      if (auto) begin
        ptr_d = ptr_q + 3'd1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= '0;
      ptr_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      ptr_q  <= ptr_d;
    end
  end

  assign o0   = data_q[0];
  assign o1   = data_q[1];
  assign o2   = data_q[2];
  assign o3   = data_q[3];
  assign o4   = data_q[4];
  assign o5   = data_q[5];
  assign o6   = data_q[6];
  assign o7   = data_q[7];
  assign vld  = vld_q;
  assign ptr  = ptr_q;
  assign full = &vld_q;

endmodule

// File: tb/tb_dmux1t8_8_reg.sv
// Testbench for dmux1t8_8_reg.
// The stimulus process queues the expected handshake and post-edge state for every cycle.
// The monitor pops each queued entry and compares it against the DUT.
module tb_dmux1t8_8_reg;
  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] x;
  logic [2:0]   sel;
  logic         auto;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   clr;
  logic [W-1:0] o [8];
  logic [7:0]   vld;
  logic [2:0]   ptr;
  logic         full;

  dmux1t8_8_reg #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .sel(sel), .auto(auto),
    .in_valid(in_valid), .in_ready(in_ready), .clr(clr),
    .o0(o[0]), .o1(o[1]), .o2(o[2]), .o3(o[3]),
    .o4(o[4]), .o5(o[5]), .o6(o[6]), .o7(o[7]),
    .vld(vld), .ptr(ptr), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              rdy;
    logic [7:0][W-1:0] d;
    logic [7:0]        v;
    logic [2:0]        p;
  } rec_t;

  rec_t q[$];

  // Reference model state: stored words, occupancy flags and the round-robin pointer.
  logic [W-1:0] m_data [8];
  logic         m_vld  [8];
  int unsigned  m_ptr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_data[i] = '0;
      m_vld[i]  = 1'b0;
    end
    m_ptr = 0;
  endtask

  // Drive one cycle of inputs, advance the model by one edge and queue the expected result.
  task automatic cycle(input logic [W-1:0] xv, input logic [2:0] s, input logic a,
                       input logic v, input logic [7:0] c);
    int unsigned tgt;
    logic        rdy;
    rec_t        r;
    @(negedge clk);
    x = xv; sel = s; auto = a; in_valid = v; clr = c;
    tgt = a ? m_ptr : 32'(s);
    rdy = !m_vld[tgt] || c[tgt];
    for (int i = 0; i < 8; i++) begin
      if (c[i]) m_vld[i] = 1'b0;
    end
    if (v && rdy) begin
      m_data[tgt] = xv;
      m_vld[tgt]  = 1'b1;
      if (a) m_ptr = (m_ptr + 1) % 8;
    end
    r.rdy = rdy;
    for (int i = 0; i < 8; i++) begin
      r.d[i] = m_data[i];
      r.v[i] = m_vld[i];
    end
    r.p = 3'(m_ptr);
    q.push_back(r);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_o%0d", tag, i), 64'(o[i]), 64'd0);
    chk({tag, "_vld"}, 64'(vld), 64'd0);
    chk({tag, "_ptr"}, 64'(ptr), 64'd0);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Assert reset between edges, check the outputs clear without a clock edge, then release.
  task automatic reset_mid(input string tag);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    clr      = '0;
    rst_n    = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: handshake sampled before the edge, registered state sampled just after it.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        r = q.pop_front();
        chk("in_ready", 64'(in_ready), 64'(r.rdy));
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) chk($sformatf("o%0d", i), 64'(o[i]), 64'(r.d[i]));
        chk("vld", 64'(vld), 64'(r.v));
        chk("ptr", 64'(ptr), 64'(r.p));
        chk("full", 64'(full), 64'(&r.v));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] c;
    rst_n = 1'b0; x = '0; sel = '0; auto = 1'b0; in_valid = 1'b0; clr = '0;
    model_reset();
    #3;
    check_reset_outputs("init");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Manual fill: channel i receives i*0x11.
    for (int i = 0; i < 8; i++) cycle(8'(i * 'h11), 3'(i), 1'b0, 1'b1, 8'h00);
    cycle(8'h00, 3'd0, 1'b0, 1'b0, 8'h00);

    // Consume channels 0 and 7 with no offer.
    cycle(8'hEE, 3'd0, 1'b0, 1'b0, 8'h81);

    // Consume-and-refill channel 3 in the same cycle.
    cycle(8'hC3, 3'd3, 1'b0, 1'b1, 8'h08);
    cycle(8'h00, 3'd0, 1'b0, 1'b0, 8'h00);

    // Auto-mode fill, pointer wrap, then a stalled ninth offer.
    reset_mid("rst_a");
    for (int i = 0; i < 8; i++) cycle(8'hA0 + 8'(i), 3'd5, 1'b1, 1'b1, 8'h00);
    cycle(8'hA8, 3'd5, 1'b1, 1'b1, 8'h00);

    // Free channels 0 and 1, refill them so ptr=2 while channel 2 is occupied.
    cycle(8'h00, 3'd0, 1'b1, 1'b0, 8'h03);
    cycle(8'hB0, 3'd0, 1'b1, 1'b1, 8'h00);
    cycle(8'hB1, 3'd0, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) cycle(8'hD0 + 8'(i), 3'd7, 1'b1, 1'b1, 8'h00);
    cycle(8'hD2, 3'd7, 1'b1, 1'b1, 8'h04);

    // Fill five channels, reset mid-operation, then the first auto accept must land in channel 0.
    reset_mid("rst_b");
    for (int i = 0; i < 5; i++) cycle(8'h50 + 8'(i), 3'd0, 1'b1, 1'b1, 8'h00);
    reset_mid("rst_c");
    cycle(8'h5A, 3'd6, 1'b1, 1'b1, 8'h00);
    cycle(8'h00, 3'd0, 1'b1, 1'b0, 8'h00);

    // Randomized traffic with sparse clears and mode switching.
    for (int n = 0; n < 400; n++) begin
      c = '0;
      for (int b = 0; b < 8; b++) c[b] = ($urandom_range(0, 3) == 0);
      cycle(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), c);
    end

    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmux1t8_8_reg.md
DMUX1T8_8_REG -- requirements
Module: dmux1t8_8_reg

Interface
REQ-001 SHALL have parameter W, default 8, meaning data width of the input and of each output channel.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port x  input  W  data to distribute.
REQ-005 SHALL have port sel  input  3  target channel when auto=0.
REQ-006 SHALL have port auto  input  1  1 = target is the internal pointer ptr; 0 = target is sel.
REQ-007 SHALL have port in_valid  input  1  x is offered this cycle.
REQ-008 SHALL have port in_ready  output  1  target channel can accept this cycle.
REQ-009 SHALL have port clr  input  8  per-channel consume/clear strobe, bit i for channel i.
REQ-010 SHALL have ports o0..o7  output  W each  registered channel data.
REQ-011 SHALL have port vld  output  8  bit i = channel i holds unconsumed data.
REQ-012 SHALL have port ptr  output  3  current auto-mode pointer.
REQ-013 SHALL have port full  output  1  all eight channels hold unconsumed data.

Function
REQ-014 SHALL define target = auto ? ptr : sel, evaluated combinationally each cycle.
REQ-015 SHALL drive in_ready = ~vld[target] | clr[target], combinationally.
REQ-016 SHALL accept a word when in_valid & in_ready are both 1 at a rising clk edge; no other condition accepts.
REQ-017 SHALL, on accept, load o<target> with x and set vld[target] to 1, both visible the cycle after the edge (latency 1).
REQ-018 SHALL hold every non-target channel's data unchanged on accept; o registers change only on accept to that channel or reset.
REQ-019 SHALL clear vld[i] at the edge where clr[i]=1 and no accept targets channel i; o<i> keeps its value.
REQ-020 SHALL, when clr[target]=1 and an accept targets the same channel in the same cycle, leave vld[target]=1 and load the new x (consume-and-refill, no bubble).
REQ-021 SHALL ignore clr[i] when vld[i]=0 (no state change).
REQ-022 SHALL increment ptr by 1 modulo 8 (7 -> 0) on each accept made while auto=1; ptr SHALL NOT change on accepts with auto=0 or on non-accepting cycles.
REQ-023 SHALL stall in auto mode when vld[ptr]=1 and clr[ptr]=0: in_ready=0, ptr holds; it SHALL NOT skip ahead to a free channel.
REQ-024 SHALL allow auto and sel to change on any cycle; the new target applies in that same cycle.
REQ-025 SHALL drive full = &vld, combinationally from the vld register.
REQ-026 SHALL allow any combination of clr bits in one cycle, each applied independently per REQ-019..021.

Reset
REQ-027 SHALL, while rst_n=0, immediately force o0..o7 = 0, vld = 8'h00, ptr = 0, independent of clk.
REQ-028 SHALL, during reset, give in_ready = 1 and full = 0 as a consequence of vld = 0.
REQ-029 SHALL, on reset asserted mid-operation, discard all stored words and pointer position; the first accept after deassertion in auto mode targets channel 0.
REQ-030 SHALL resume normal operation at the first rising clk edge after rst_n returns to 1.

Verification
REQ-031 Directed: auto=0, offer x=8'h00..8'h77 in steps of 8'h11 with sel=0..7, one per cycle, clr=0 -> o<i>=8'h<ii>, vld=8'hFF, full=1, ptr=0.
REQ-032 Directed: auto=1, offer 8'hA0..8'hA7 back-to-back with clr=0 -> channels 0..7 filled in order, ptr wraps to 0; ninth offer sees in_ready=0 and ptr stays 0.
REQ-033 Directed: channel 3 full with 8'h33; same cycle assert clr=8'h08 and offer x=8'hC3 with sel=3 -> accepted, o3=8'hC3, vld[3] stays 1.
REQ-034 Directed: vld=8'hFF, pulse clr=8'h81 with in_valid=0 -> vld=8'h7E, o0/o7 unchanged, full=0.
REQ-035 Directed: auto=1, fill channels 0..4 (ptr=5), assert rst_n=0 between edges -> outputs zero immediately; after release, offer 8'h5A -> lands in o0, ptr=1.
REQ-036 Directed: auto=1, clr=0, vld[2]=1 with ptr=2, in_valid held 1 for 3 cycles -> no accept, ptr=2; then clr=8'h04 -> accept, ptr=3.
